// File: rtl/sync_down_counter_8bit.sv
// Loadable 8-bit down counter with borrow chain and wrap policies.
// Free-running, auto-reload and one-shot; Tc/Done registered.
module sync_down_counter_8bit (
  input  logic       CLK,
  input  logic       Rd,
  input  logic       Load,
  input  logic [7:0] D,
  input  logic       En,
  input  logic       Bin,
  input  logic [1:0] Mode,
  output logic [7:0] Q,
  output logic       Bout,
  output logic       Tc,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] q_q, q_d;
  logic [7:0] r_q, r_d;
  logic       tc_q, tc_d;
  logic       done_q, done_d;
  logic       cnt;

  assign cnt  = En & Bin & ~Load & (state_q == RUN);
  assign Bout = cnt & (q_q == 8'h00);
  assign Q    = q_q;
  assign Tc   = tc_q;
  assign Done = done_q;

  always_ff @(posedge CLK or negedge Rd) begin
    if (!Rd) begin
      state_q <= IDLE;
      q_q     <= 8'h00;
      r_q     <= 8'h00;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (Load) begin
      // load wins over a same-cycle borrow
      q_d     = D;
      r_d     = D;
      state_d = RUN;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          q_d = 8'h00;
        end
        RUN: begin
          if (cnt) begin
            if (q_q != 8'h00) begin
              q_d = q_q - 8'd1;
            end else begin
              tc_d = 1'b1;
              unique case (Mode)
                2'b01: q_d = r_q;
                2'b10: begin
                  q_d     = 8'h00;
                  state_d = HALT;
                  done_d  = 1'b1;
                end
                default: q_d = 8'hFF;
              endcase
            end
          end
        end
        HALT: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_down_counter_8bit.sv
// Bench for sync_down_counter_8bit: reference model plus
// directed vectors, including a two-stage cascade.
module tb_sync_down_counter_8bit;

  logic       CLK = 1'b0;
  logic       Rd = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] D = 8'h00;
  logic [7:0] D_hi = 8'h00;
  logic       En = 1'b0;
  logic       Bin = 1'b0;
  logic [1:0] Mode = 2'b00;
  logic [7:0] Q, Q_hi;
  logic       Bout, Bout_hi;
  logic       Tc, Tc_hi;
  logic       Done, Done_hi;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  sync_down_counter_8bit u_lo (
    .CLK(CLK), .Rd(Rd), .Load(Load), .D(D),
    .En(En), .Bin(Bin), .Mode(Mode),
    .Q(Q), .Bout(Bout), .Tc(Tc), .Done(Done)
  );

  sync_down_counter_8bit u_hi (
    .CLK(CLK), .Rd(Rd), .Load(Load), .D(D_hi),
    .En(En), .Bin(Bout), .Mode(Mode),
    .Q(Q_hi), .Bout(Bout_hi), .Tc(Tc_hi), .Done(Done_hi)
  );

  // Reference model of the low stage
  int m_q;
  int m_r;
  bit m_armed;
  bit m_tc;
  bit m_done;

  always @(posedge CLK or negedge Rd) begin
    if (!Rd) begin
      m_q <= 0; m_r <= 0; m_armed <= 0;
      m_tc <= 0; m_done <= 0;
    end else if (Load) begin
      m_q <= D; m_r <= D; m_armed <= 1;
      m_tc <= 0; m_done <= 0;
    end else begin
      m_tc <= 0;
      if (m_armed && En && Bin) begin
        if (m_q > 0) begin
          m_q <= (m_q + 255) % 256;
        end else begin
          m_tc <= 1;
          if (Mode == 2'b10) begin
            m_armed <= 0;
            m_done <= 1;
          end else if (Mode == 2'b01) begin
            m_q <= m_r;
          end else begin
            m_q <= 255;
          end
        end
      end
    end
  end

  function automatic bit model_bout();
    return m_armed && En && Bin && !Load && (m_q == 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    chk("model_q", Q, m_q);
    chk("model_bout", Bout, model_bout());
    chk("model_tc", Tc, m_tc);
    chk("model_done", Done, m_done);
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic expect_o(input int q, input int b,
                          input int t, input int d);
    @(negedge CLK);
    chk("lit_q", Q, q);
    chk("lit_bout", Bout, b);
    chk("lit_tc", Tc, t);
    chk("lit_done", Done, d);
  endtask

  task automatic load(input logic [7:0] v, input logic [1:0] m);
    Load = 1'b1; D = v; Mode = m;
    tick();
    Load = 1'b0;
  endtask

  task automatic load16(input logic [15:0] v);
    Load = 1'b1; D = v[7:0]; D_hi = v[15:8]; Mode = 2'b00;
    tick();
    Load = 1'b0;
  endtask

  task automatic expect16(input int v, input int hb);
    @(negedge CLK);
    chk("casc_q", {Q_hi, Q}, v);
    chk("casc_hi_bout", Bout_hi, hb);
  endtask

  initial begin
    expect_o(8'h00, 0, 0, 0);
    tick();
    Rd = 1'b1; En = 1'b1; Bin = 1'b1;

    // free-running
    load(8'h03, 2'b00);
    expect_o(8'h03, 0, 0, 0); tick();
    expect_o(8'h02, 0, 0, 0); tick();
    expect_o(8'h01, 0, 0, 0); tick();
    expect_o(8'h00, 1, 0, 0); tick();
    expect_o(8'hFF, 0, 1, 0); tick();
    expect_o(8'hFE, 0, 0, 0);

    // auto-reload
    load(8'h02, 2'b01);
    expect_o(8'h02, 0, 0, 0); tick();
    expect_o(8'h01, 0, 0, 0); tick();
    expect_o(8'h00, 1, 0, 0); tick();
    expect_o(8'h02, 0, 1, 0); tick();
    expect_o(8'h01, 0, 0, 0); tick();
    expect_o(8'h00, 1, 0, 0); tick();
    expect_o(8'h02, 0, 1, 0);

    // auto-reload with R == 0 borrows every cycle
    load(8'h00, 2'b01);
    expect_o(8'h00, 1, 0, 0); tick();
    expect_o(8'h00, 1, 1, 0); tick();
    expect_o(8'h00, 1, 1, 0);

    // one-shot
    load(8'h01, 2'b10);
    expect_o(8'h01, 0, 0, 0); tick();
    expect_o(8'h00, 1, 0, 0); tick();
    expect_o(8'h00, 0, 1, 1); tick();
    expect_o(8'h00, 0, 0, 1);
    En = 1'b0; tick();
    expect_o(8'h00, 0, 0, 1);
    En = 1'b1; tick();
    expect_o(8'h00, 0, 0, 1);
    load(8'h05, 2'b10);
    expect_o(8'h05, 0, 0, 0); tick();
    expect_o(8'h04, 0, 0, 0);

    // load collides with a borrow
    load(8'h01, 2'b00);
    expect_o(8'h01, 0, 0, 0); tick();
    expect_o(8'h00, 1, 0, 0);
    tick();
    expect_o(8'hFF, 0, 1, 0);
    load(8'h00, 2'b00);
    Load = 1'b1; D = 8'h7A;
    expect_o(8'h00, 0, 0, 0); tick();
    Load = 1'b0;
    expect_o(8'h7A, 0, 0, 0);

    // async reset drops a pending Tc
    load(8'h00, 2'b00);
    tick();
    #1 Rd = 1'b0;
    #1;
    chk("rst_q", Q, 8'h00);
    chk("rst_tc", Tc, 0);
    chk("rst_done", Done, 0);
    tick();
    Rd = 1'b1;
    expect_o(8'h00, 0, 0, 0); tick();
    expect_o(8'h00, 0, 0, 0); tick();
    expect_o(8'h00, 0, 0, 0);

    // two-stage cascade
    load16(16'h0100);
    expect16(16'h0100, 0); tick();
    expect16(16'h00FF, 0); tick();
    expect16(16'h00FE, 0);
    load16(16'h0002);
    expect16(16'h0002, 0); tick();
    expect16(16'h0001, 0); tick();
    expect16(16'h0000, 1); tick();
    expect16(16'hFFFF, 0); tick();
    expect16(16'hFFFE, 0);

    @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_down_counter_8bit.md
# sync_down_counter_8bit

Loadable 8-bit synchronous down counter, the counting-down counterpart of the team's 8-bit synchronous up counter. It provides a parallel load, a count enable, and a borrow-in/borrow-out pair for cascading stages into wider counters. It has three wrap policies: free-running, auto-reload and one-shot. It is used as a programmable divider and as an interval timer next to the up counters in the exam designs.

## Interface
Parameters: none (width fixed at 8).
- CLK  in  1  rising-edge clock
- Rd  in  1  asynchronous active-low reset; Rd=0 forces reset state immediately
- Load  in  1  synchronous parallel load strobe, highest priority after Rd
- D  in  8  load value
- En  in  1  count enable
- Bin  in  1  borrow-in; tie 1 for the least significant stage, else driven by the lower stage's Bout
- Mode  in  2  wrap policy: 00 free-running, 01 auto-reload, 10 one-shot, 11 treated as 00
- Q  out  8  current count
- Bout  out  1  borrow-out (combinational)
- Tc  out  1  registered terminal-count pulse
- Done  out  1  one-shot expired flag

## Operation
- Internal state: Q[7:0], reload register R[7:0], FSM {IDLE, RUN, HALT}.
- Reset (Rd=0, asynchronous): Q=8'h00, R=8'h00, FSM=IDLE, Tc=0, Done=0.
- The internal count strobe is cnt = En & Bin & ~Load & (FSM==RUN).
- Bout = cnt & (Q==8'h00). Bout is 0 in IDLE and HALT and whenever Load=1.
- Load=1 at a rising edge, in any state:
  - Q<=D, R<=D, FSM<=RUN, Done<=0, Tc<=0.
  - Any borrow that would occur in the same cycle is discarded.
- IDLE: Q holds 8'h00 and En is ignored. Only Load exits IDLE.
- RUN, cnt=1, Q!=0: Q<=Q-1.
- RUN, cnt=1, Q==0 (borrow event), with Tc<=1 for every mode:
  - Mode 00/11: Q<=8'hFF, stay in RUN.
  - Mode 01: Q<=R, stay in RUN. If R==0, Q stays 0 and a borrow occurs on every enabled cycle.
  - Mode 10: Q holds 8'h00, FSM<=HALT, Done<=1.
- RUN, cnt=0: Q holds.
- HALT: Q holds, Done=1, En and Bin are ignored. Only Load (to RUN) or Rd (to IDLE) exits HALT.
- Tc is 1 only for the single cycle after a borrow event, and 0 otherwise.
- Mode is sampled at each edge. A change mid-run affects only the next borrow event.
- Cascading: stage k+1 Bin = stage k Bout, with a shared En and shared Load. In free-running mode the chain decrements as one wide counter, and all stages update on the same edge.
- Arithmetic is 8-bit modulo. The decrement has no intermediate carry width beyond 8 bits.

## Timing
- Load-to-Q latency: 1 edge. Q=D is visible right after the loading edge.
- Decrement latency: 1 edge per enabled cycle.
- Bout is combinational from registered Q/FSM and the live En, Bin, Load inputs, with no register stage. Cascade depth is limited by the ripple of the Bout chain within one cycle.
- Tc and Done are registered. Each asserts on the edge that performs the borrow.
- Rd deassertion is not synchronized internally. The first action occurs on the first rising edge with Rd=1.
- Reset mid-count clears everything asynchronously. A pending Tc pulse is dropped.

## Test plan
- Reset, then Load D=8'h03 with Mode=00 and En=Bin=1:
  - Q sequence 03,02,01,00,FF,FE.
  - Bout=1 only during the Q=00 cycle; Tc=1 during the Q=FF cycle.
- Load D=8'h02 with Mode=01:
  - Q sequence 02,01,00,02,01,00,02.
  - Tc pulses once per reload; R is unchanged.
- Load D=8'h01 with Mode=10:
  - Q sequence 01,00, then holds 00 with Done=1 and Tc pulsed once.
  - Toggling En produces no change; Load D=8'h05 clears Done and resumes from 05.
- Simultaneous events: with Q=00 in RUN, cnt conditions true, and Load=1 with D=8'h7A:
  - Next Q=7A, Bout=0 in that cycle, no Tc pulse.
- Two stages cascaded in free-running mode, Load 16'h0100:
  - Next values are 00FF, then 00FE.
  - The high-stage Bout goes 1 only when the combined value is 0000 (the following value is FFFF).
- Assert Rd=0 asynchronously mid-count between edges:
  - Q=00, Tc=0, Done=0 immediately.
  - After release, En=1 produces no counting until Load.
